// File: rtl/btn_debounce.sv
// Button debouncer: synchronises a raw pin, requests a settling window from an
// external timer and commits a new level only if the input held for the whole window.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_raw,
  input  logic             i_tmr_pulse,
  output logic             o_start_tmr,
  output logic             o_btn_level,
  output logic             o_btn_press,
  output logic             o_btn_release,
  output logic [CNT_W-1:0] o_press_count
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  logic                   r_bounce;
  logic                   r_start;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_bounce_nxt;
  logic                   w_start_nxt;
  logic                   w_level_nxt;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_STABLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bounce_nxt  = r_bounce;
    w_start_nxt   = 1'b0;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_STABLE: begin
        if (w_s != r_level) begin
          w_start_nxt  = 1'b1;
          w_bounce_nxt = 1'b0;
          w_state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // any return to the committed level during the window taints it
        if (w_s == r_level) begin
          w_bounce_nxt = 1'b1;
        end
        if (i_tmr_pulse) begin
          if (w_s == r_level) begin
            w_state_nxt = ST_STABLE;
          end else if (!r_bounce) begin
            w_level_nxt   = w_s;
            w_press_nxt   = (w_s != IDLE_LEVEL);
            w_release_nxt = (w_s == IDLE_LEVEL);
            w_state_nxt   = ST_STABLE;
            if (w_s != IDLE_LEVEL) begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_start_nxt  = 1'b1;
            w_bounce_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bounce  <= 1'b0;
      r_start   <= 1'b0;
      r_level   <= IDLE_LEVEL;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_bounce  <= w_bounce_nxt;
      r_start   <= w_start_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign o_start_tmr   = r_start;
  assign o_btn_level   = r_level;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;
  assign o_press_count = r_cnt;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: models the window timer and scoreboards every
// committed press/release strobe against events queued by the stimulus.
module tb_btn_debounce;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       raw;
  logic       tmr_gen = 1'b0;
  logic       stray;
  logic       pulse;
  assign pulse = tmr_gen | stray;

  logic       start, level, press, release_s;
  logic [7:0] count;
  logic       start2, level2, press2, release2;
  logic [1:0] count2;

  btn_debounce #(.SYNC_STAGES(2), .IDLE_LEVEL(1'b0), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_raw(raw), .i_tmr_pulse(pulse),
    .o_start_tmr(start), .o_btn_level(level), .o_btn_press(press),
    .o_btn_release(release_s), .o_press_count(count)
  );

  btn_debounce #(.SYNC_STAGES(2), .IDLE_LEVEL(1'b0), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_btn_raw(raw), .i_tmr_pulse(pulse),
    .o_start_tmr(start2), .o_btn_level(level2), .o_btn_press(press2),
    .o_btn_release(release2), .o_press_count(count2)
  );

  typedef struct packed {
    logic       is_press;
    logic [7:0] cnt;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] exp_cnt;
  int         n_total = 0;
  int         n_bad = 0;
  int         n_start = 0;
  int         n_restart = 0;
  int         tcnt = 0;
  logic       pulse_at_edge = 1'b0;
  logic       prev_start = 1'b0;
  logic       prev_strobe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic is_p);
    ev_t e;
    if (is_p) exp_cnt = exp_cnt + 8'd1;
    e.is_press = is_p;
    e.cnt      = exp_cnt;
    sb.push_back(e);
  endtask

  // timer: pulse sampled 9 edges after the edge that raised START_TMR
  always @(negedge clk) begin
    logic p;
    p = (tcnt == 1);
    if (tcnt != 0) tcnt = tcnt - 1;
    if (start) tcnt = 8;
    tmr_gen = p;
  end

  always @(posedge clk) pulse_at_edge <= pulse;

  always @(negedge clk) begin
    ev_t e;
    if (start) begin
      n_start++;
      if (pulse_at_edge) n_restart++;
    end
    if (start && prev_start) check("start_width", {30'd0, prev_start, start}, 32'd1);
    if ((press || release_s) && prev_strobe)
      check("strobe_width", {31'd0, prev_strobe}, 32'd0);
    if (press || release_s) begin
      check("press_and_release", {31'd0, press & release_s}, 32'd0);
      check("commit_latency", {31'd0, pulse_at_edge}, 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, press, release_s}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {31'd0, press}, {31'd0, e.is_press});
        check("level_at_strobe", {31'd0, level}, {31'd0, e.is_press});
        check("press_count", {24'd0, count}, {24'd0, e.cnt});
        check("press_count_w2", {30'd0, count2}, {30'd0, e.cnt[1:0]});
      end
    end
    prev_start  = start;
    prev_strobe = press | release_s;
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    exp_cnt = '0;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic press_release();
    int s0;
    s0 = n_start;
    expect_ev(1'b1);
    raw = 1'b1;
    tick(25);
    check("pr_level_hi", {31'd0, level}, 32'd1);
    expect_ev(1'b0);
    raw = 1'b0;
    tick(25);
    check("pr_level_lo", {31'd0, level}, 32'd0);
    check("pr_starts", n_start - s0, 32'd2);
    check("pr_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int s0, r0;
    raw     = 1'b0;
    stray   = 1'b0;
    rst     = 1'b1;
    exp_cnt = '0;

    tick(3);
    check("rst_level", {31'd0, level}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_press", {31'd0, press}, 32'd0);
    check("rst_release", {31'd0, release_s}, 32'd0);
    check("rst_count", {24'd0, count}, 32'd0);
    rst = 1'b0;
    tick(5);
    check("idle_no_start", n_start, 32'd0);

    // stray pulse while stable must be ignored
    s0 = n_start;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(5);
    check("stray_no_start", n_start - s0, 32'd0);
    check("stray_level", {31'd0, level}, 32'd0);

    // clean press and release
    s0 = n_start;
    expect_ev(1'b1);
    raw = 1'b1;
    tick(25);
    check("clean_starts", n_start - s0, 32'd1);
    check("clean_level", {31'd0, level}, 32'd1);
    check("clean_count", {24'd0, count}, 32'd1);
    check("clean_sb", sb.size(), 32'd0);
    expect_ev(1'b0);
    raw = 1'b0;
    tick(25);
    check("clean_rel_level", {31'd0, level}, 32'd0);
    check("clean_rel_sb", sb.size(), 32'd0);

    // glitch: short high pulse is discarded
    s0 = n_start;
    raw = 1'b1;
    tick(3);
    raw = 1'b0;
    tick(25);
    check("glitch_starts", n_start - s0, 32'd1);
    check("glitch_level", {31'd0, level}, 32'd0);
    check("glitch_count", {24'd0, count}, 32'd1);

    // bounce: first window restarts, second commits
    s0 = n_start;
    r0 = n_restart;
    expect_ev(1'b1);
    for (int i = 0; i < 5; i++) begin
      raw = (i % 2 == 0);
      tick(2);
    end
    raw = 1'b1;
    tick(40);
    check("bounce_starts", n_start - s0, 32'd2);
    check("bounce_restarts", n_restart - r0, 32'd1);
    check("bounce_level", {31'd0, level}, 32'd1);
    check("bounce_sb", sb.size(), 32'd0);
    expect_ev(1'b0);
    raw = 1'b0;
    tick(25);
    check("bounce_rel_sb", sb.size(), 32'd0);

    // reset mid-window: pending pulse lands during reset, new window after
    s0 = n_start;
    raw = 1'b1;
    tick(6);
    check("mw_first_start", n_start - s0, 32'd1);
    do_reset(12);
    check("mw_level_after_rst", {31'd0, level}, 32'd0);
    check("mw_count_after_rst", {24'd0, count}, 32'd0);
    s0 = n_start;
    expect_ev(1'b1);
    tick(25);
    check("mw_restart_once", n_start - s0, 32'd1);
    check("mw_level", {31'd0, level}, 32'd1);
    check("mw_sb", sb.size(), 32'd0);
    expect_ev(1'b0);
    raw = 1'b0;
    tick(25);
    check("mw_rel_sb", sb.size(), 32'd0);

    // wrap: narrow counter runs 1,2,3,0,1
    do_reset(2);
    tick(3);
    for (int i = 0; i < 5; i++) press_release();
    check("wrap_count_w2", {30'd0, count2}, 32'd1);
    check("wrap_count_w8", {24'd0, count}, 32'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
